idct_transpose: RTL and testbench
=================================

IDCT_TRANSPOSE -- requirements
Module: idct_transpose

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  din carries a row-IDCT output sample this cycle.
REQ-004 SHALL have port din  input  16  signed two's-complement sample, row-major order within an 8x8 block.
REQ-005 SHALL have port in_ready  output  1  block can accept din this cycle.
REQ-006 SHALL have port out_valid  output  1  dout holds a valid sample for the column IDCT.
REQ-007 SHALL have port dout  output  16  transposed sample, column-major order.
REQ-008 SHALL have port out_first  output  1  high with out_valid on the first sample (index 0) of each output block.

Function
REQ-009 SHALL buffer data in two 64-entry x 16-bit banks (ping-pong) with write-bank select wsel, read-bank select rsel, and per-bank full flags full[1:0].
REQ-010 SHALL accept a sample on a rising edge when in_valid && in_ready, writing it to bank wsel at address wr_cnt (6-bit, 0..63), then incrementing wr_cnt.
REQ-011 SHALL drive in_ready = !full[wsel], combinationally.
REQ-012 SHALL, on acceptance with wr_cnt==63, set full[wsel], toggle wsel and wrap wr_cnt to 0 on the same edge.
REQ-013 SHALL run a reader FSM with states IDLE and READ and a 6-bit rd_cnt.
REQ-014 SHALL, in IDLE with full[rsel]=1, move to READ with rd_cnt=0 on the next edge.
REQ-015 SHALL, in READ, present read address {rd_cnt[2:0], rd_cnt[5:3]} (row = rd_cnt[2:0], col = rd_cnt[5:3], i.e. address row*8+col) to bank rsel each cycle and increment rd_cnt.
REQ-016 SHALL, in READ with rd_cnt==63, clear full[rsel] and toggle rsel; stay in READ with rd_cnt=0 if full[~rsel] is 1 on that edge (back-to-back blocks), else go to IDLE.
REQ-017 SHALL use a synchronous-read memory plus one output register: out_valid, out_first and dout update one edge after the corresponding read address cycle.
REQ-018 SHALL give a latency of exactly 2 edges: the 64th sample accepted at edge N produces its block's first out_valid after edge N+2.
REQ-019 SHALL assert out_valid for exactly 64 consecutive cycles per block, with out_first high only on the first of them.
REQ-020 SHALL pass sample values bit-exact (no rounding, scaling or sign change).
REQ-021 SHALL allow setting full[wsel] and clearing full[rsel] on the same edge when they address different banks; the same bank SHALL never be set and cleared on the same edge.
REQ-022 SHALL ignore din when in_valid=0 or in_ready=0 (no write, no counter change); input gaps stretch a block but do not reorder it.
REQ-023 SHALL sustain a continuous 1 sample/clock input without deasserting in_ready.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear wr_cnt, rd_cnt, wsel, rsel, full[1:0], set FSM to IDLE, and drive out_valid=0, out_first=0, dout=16'h0000.
REQ-025 SHALL discard any partial or buffered block on reset mid-operation; memory contents need not be cleared.
REQ-026 SHALL hold in_ready=1 after reset release.

Structure
REQ-027 SHALL take DATA_W=16, BLK_DIM=8 and BLK_SIZE=64 from the shared package idct_pkg, also used by idct_row and the column stage.
REQ-028 SHALL instantiate one sub-module idct_tp_ram: 128x16 simple dual-port RAM, one write port, one synchronous read port; bank select forms the address MSB.

Verification
REQ-029 SHALL cover: ramp din=0..63 with in_valid continuously high -> dout 0,8,16,...,56,1,9,...,63, with out_first on the value 0, first out_valid 2 edges after the 64th accept.
REQ-030 SHALL cover: two blocks back-to-back (0..63 then 64..127) -> out_valid high for 128 continuous cycles, second block begins 64,72,..., in_ready never low.
REQ-031 SHALL cover: ramp with in_valid low every third cycle -> output order identical to the first scenario, out_valid contiguous for 64 cycles.
REQ-032 SHALL cover: extreme values (din=16'h8000 at index 0, 16'h7FFF at index 63) -> dout 16'h8000 first, 16'h7FFF last, bit-exact.
REQ-033 SHALL cover: rst_n pulsed low after 30 samples, then a fresh ramp 0..63 -> only one output block, matching the first scenario; all outputs 0 during reset.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared IDCT constants and types used by the row stage, the transpose buffer
// and the column stage.
package idct_pkg;

    localparam int DATA_W   = 16;
    localparam int BLK_DIM  = 8;
    localparam int BLK_SIZE = BLK_DIM * BLK_DIM;
    localparam int DIM_W    = $clog2(BLK_DIM);
    localparam int CNT_W    = $clog2(BLK_SIZE);
    localparam int RAM_AW   = CNT_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_SIZE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Column-major sample index -> row-major buffer address (row*8 + col).
    function automatic logic [CNT_W-1:0] tp_addr(input logic [CNT_W-1:0] idx);
        return {idx[DIM_W-1:0], idx[CNT_W-1:DIM_W]};
    endfunction

endpackage

// File: rtl/idct_tp_ram.sv
// Two-bank transpose buffer: simple dual-port RAM with one write port and one
// synchronous read port; the bank select is the address MSB.
module idct_tp_ram
    import idct_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [RAM_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2*BLK_SIZE];

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/idct_transpose.sv
// Ping-pong 8x8 transpose buffer between the row and column IDCT stages:
// samples arrive row-major and leave column-major, two edges after block fill.
module idct_transpose
    import idct_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] din,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout,
    output logic              out_first
);

    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic              wsel;
    logic              rsel;
    logic [1:0]        full;
    logic [1:0]        full_next;
    rd_state_t         state;

    logic              accept;
    logic              wr_done;
    logic              rd_en;
    logic              rd_done;
    logic [DATA_W-1:0] ram_rdata;

    assign in_ready = !full[wsel];
    assign accept   = in_valid && in_ready;
    assign wr_done  = accept && (wr_cnt == CNT_LAST);
    assign rd_en    = (state == READ);
    assign rd_done  = rd_en && (rd_cnt == CNT_LAST);

    // The writer only sets a bank that is empty and the reader only clears a
    // bank that is full, so set and clear can never hit the same bank.
    always_comb begin
        full_next = full;
        if (wr_done) begin
            full_next[wsel] = 1'b1;
        end
        if (rd_done) begin
            full_next[rsel] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            wsel   <= 1'b0;
            full   <= 2'b00;
        end else begin
            full <= full_next;
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (wr_done) begin
                wsel <= ~wsel;
            end
        end
    end

    // Reader FSM; out_valid/out_first line up with the RAM's registered data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            rsel      <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_first <= rd_en && (rd_cnt == '0);
            case (state)
                IDLE: begin
                    if (full[rsel]) begin
                        state  <= READ;
                        rd_cnt <= '0;
                    end
                end
                READ: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_cnt == CNT_LAST) begin
                        rsel <= ~rsel;
                        if (!full[~rsel]) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    idct_tp_ram u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({wsel, wr_cnt}),
        .wdata (din),
        .re    (rd_en),
        .raddr ({rsel, tp_addr(rd_cnt)}),
        .rdata (ram_rdata)
    );

    // The read register has no reset, so dout is held at zero outside a block.
    assign dout = out_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_idct_transpose.sv
// Directed bench for idct_transpose: ramps, back-to-back blocks, input gaps,
// extreme values and a mid-block reset, checked against hand-derived order.
module tb_idct_transpose;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] din;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] dout;
    logic        out_first;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stall_cnt = 0;

    logic [15:0] src [128];
    logic [15:0] out_q [$];
    bit          first_q [$];
    int          oedge_q [$];
    int          acc_q [$];

    idct_transpose dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din       (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .dout      (dout),
        .out_first (out_first)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Everything is logged on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) acc_q.push_back(cyc + 1);
        if (rst_n && in_valid && !in_ready) stall_cnt++;
        if (out_valid) begin
            out_q.push_back(dout);
            first_q.push_back(out_first);
            oedge_q.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d);
        int guard;
        guard = 0;
        in_valid = v;
        din = d;
        @(negedge clk);
        while (v && !in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clearLogs();
        out_q.delete();
        first_q.delete();
        oedge_q.delete();
        acc_q.delete();
        stall_cnt = 0;
    endtask

    task automatic sendStream(input int n, input bit gaps);
        int c;
        int k;
        c = 0;
        k = 0;
        while (k < n) begin
            if (gaps && (c % 3 == 2)) begin
                applyStimulus(1'b0, 16'h0000);
            end else begin
                applyStimulus(1'b1, src[k]);
                k++;
            end
            c++;
        end
    endtask

    task automatic waitOutputs(input int n);
        int guard;
        guard = 0;
        while (out_q.size() < n && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Output k of block b is source sample row=(k%8), col=(k/8) of that block.
    task automatic checkStream(input string name, input int n);
        int blk;
        int i;
        int m;
        checkOutput({name, " count"}, out_q.size(), n);
        m = (out_q.size() < n) ? out_q.size() : n;
        for (int k = 0; k < m; k++) begin
            blk = k / 64;
            i   = k % 64;
            checkOutput($sformatf("%s dout[%0d]", name, k), out_q[k], src[blk*64 + (i%8)*8 + i/8]);
            checkOutput($sformatf("%s first[%0d]", name, k), first_q[k], (i == 0));
        end
        if (out_q.size() >= n) begin
            checkOutput({name, " contiguous"}, oedge_q[n-1] - oedge_q[0], n - 1);
        end
        if (acc_q.size() >= 64 && out_q.size() >= 1) begin
            checkOutput({name, " latency"}, oedge_q[0] - acc_q[63], 2);
        end
    endtask

    task automatic loadRamp();
        for (int k = 0; k < 128; k++) src[k] = 16'(k);
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, " out_valid"}, out_valid, 0);
        checkOutput({name, " out_first"}, out_first, 0);
        checkOutput({name, " dout"}, dout, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        din      = 16'h0000;

        repeat (3) begin
            @(negedge clk);
            checkIdleOutputs("in reset");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready after reset", in_ready, 1);
        checkIdleOutputs("after reset");
        @(posedge clk);
        #1;

        $display("[TB] single ramp");
        loadRamp();
        clearLogs();
        sendStream(64, 1'b0);
        waitOutputs(64);
        checkStream("ramp", 64);

        $display("[TB] back-to-back blocks");
        clearLogs();
        sendStream(128, 1'b0);
        waitOutputs(128);
        checkStream("b2b", 128);
        checkOutput("b2b stalls", stall_cnt, 0);
        if (acc_q.size() >= 128) begin
            checkOutput("b2b accept span", acc_q[127] - acc_q[0], 127);
            if (out_q.size() >= 65)
                checkOutput("b2b blk2 latency", oedge_q[64] - acc_q[127], 2);
        end else begin
            checkOutput("b2b accept count", acc_q.size(), 128);
        end

        $display("[TB] ramp with gaps");
        clearLogs();
        sendStream(64, 1'b1);
        waitOutputs(64);
        checkStream("gaps", 64);

        $display("[TB] extreme values");
        src[0]  = 16'h8000;
        src[63] = 16'h7FFF;
        clearLogs();
        sendStream(64, 1'b0);
        waitOutputs(64);
        checkStream("extreme", 64);
        if (out_q.size() >= 64) begin
            checkOutput("extreme first", out_q[0], 16'h8000);
            checkOutput("extreme last", out_q[63], 16'h7FFF);
        end

        $display("[TB] reset mid-block");
        loadRamp();
        clearLogs();
        sendStream(30, 1'b0);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkIdleOutputs("mid reset");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearLogs();
        @(negedge clk);
        checkOutput("ready after mid reset", in_ready, 1);
        @(posedge clk);
        #1;
        sendStream(64, 1'b0);
        waitOutputs(64);
        repeat (80) @(posedge clk);
        #1;
        checkStream("post reset", 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
